reorder_buffer: RTL and testbench

Circular reorder buffer for the out-of-order core. It allocates entries in program order from dispatch and accepts results from the common data bus by tag. It answers operand-tag lookups from the reservation station and retires completed entries in order to the architectural register file. It is the producer side of the ROB contents that the reservation station reads.

---
 rtl/rob_pkg.sv | 19 +
 rtl/rob_ptr.sv | 24 ++
 rtl/reorder_buffer.sv | 175 +++++++++++++++++
 tb/tb_reorder_buffer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer and its consumers (reservation
// station). Holds default widths, the entry layout and the tag type.
package rob_pkg;
    localparam int ROB_ROW_COUNT = 64;
    localparam int REG_W         = 6;
    localparam int DATA_W        = 32;
    localparam int TAG_W         = $clog2(ROB_ROW_COUNT);

    // Tag handed out at allocation and used by RS operand lookups
    typedef logic [TAG_W-1:0] rob_tag_t;

    // One ROB row: valid while in flight, done once its result is written back
    typedef struct packed {
        logic              valid;
        logic              done;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] value;
    } rob_entry_t;
endpackage

// File: rtl/rob_ptr.sv
// Wrap-bit pointer: low bits index the ROB row, MSB toggles on each wrap so
// head/tail comparison can tell full from empty.
module rob_ptr #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] ptr
);
    logic [W-1:0] ptr_reg;

    // Pointer register: clear wins over increment
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ptr_reg <= '0;
        end else if (inc) begin
            ptr_reg <= ptr_reg + 1'b1;
        end
    end

    assign ptr = ptr_reg;
endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, tagged writeback from the CDB,
// two combinational operand lookups and in-order single retire per cycle.
// Optional feature macro ROB_WB_BYPASS_EN forwards a same-cycle writeback to
// the lookup ports and to the commit port.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int ROB_ROW_COUNT = rob_pkg::ROB_ROW_COUNT,
    parameter int REG_W         = rob_pkg::REG_W,
    parameter int DATA_W        = rob_pkg::DATA_W,
    localparam int TAG_W        = $clog2(ROB_ROW_COUNT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid,
    input  logic [REG_W-1:0]  alloc_dest,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic [DATA_W-1:0] wb_value,
    input  logic [TAG_W-1:0]  rd_tag0,
    input  logic [TAG_W-1:0]  rd_tag1,
    output logic              rd_ready0,
    output logic              rd_ready1,
    output logic [DATA_W-1:0] rd_value0,
    output logic [DATA_W-1:0] rd_value1,
    output logic              commit_valid,
    output logic [REG_W-1:0]  commit_dest,
    output logic [DATA_W-1:0] commit_value,
    input  logic              commit_ready,
    input  logic              flush,
    output logic [TAG_W:0]    count,
    output logic              empty,
    output logic              full
);
    typedef struct packed {
        logic              valid;
        logic              done;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] value;
    } entry_t;

    entry_t           entries [ROB_ROW_COUNT];
    logic [TAG_W:0]   head_ptr;
    logic [TAG_W:0]   tail_ptr;
    logic [TAG_W:0]   count_reg;
    logic [TAG_W-1:0] head_idx;
    logic [TAG_W-1:0] tail_idx;
    logic             alloc_fire;
    logic             commit_fire;
    logic             wb_hit;
    logic             head_byp;
    entry_t           head_entry;

    assign head_idx   = head_ptr[TAG_W-1:0];
    assign tail_idx   = tail_ptr[TAG_W-1:0];
    assign head_entry = entries[head_idx];

    assign full  = (head_idx == tail_idx) && (head_ptr[TAG_W] != tail_ptr[TAG_W]);
    assign empty = (head_ptr == tail_ptr);

    // Allocation only looks at full: a retire in the same cycle frees nothing yet
    assign alloc_ready = !full;
    assign alloc_tag   = tail_idx;
    assign alloc_fire  = alloc_valid && !full && !flush;

    // Writebacks to rows not in flight are dropped
    assign wb_hit = wb_valid && entries[wb_tag].valid;

`ifdef ROB_WB_BYPASS_EN
    assign head_byp = wb_hit && (wb_tag == head_idx);
`else
    assign head_byp = 1'b0;
`endif

    // Commit port; dest/value read as zero whenever nothing is retireable
    always_comb begin
        commit_valid = head_entry.valid && (head_entry.done || head_byp);
        commit_dest  = '0;
        commit_value = '0;
        if (commit_valid) begin
            commit_dest  = head_entry.dest;
            commit_value = head_byp ? wb_value : head_entry.value;
        end
    end

    assign commit_fire = commit_valid && commit_ready && !flush;

    rob_ptr #(.W(TAG_W + 1)) u_head (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (commit_fire),
        .ptr   (head_ptr)
    );

    rob_ptr #(.W(TAG_W + 1)) u_tail (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (alloc_fire),
        .ptr   (tail_ptr)
    );

    // Occupancy tracks allocations minus retirements
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + (TAG_W + 1)'(alloc_fire) - (TAG_W + 1)'(commit_fire);
        end
    end

    assign count = count_reg;

    // Entry storage: reset wipes everything, flush only drops valid bits
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ROB_ROW_COUNT; i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < ROB_ROW_COUNT; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else begin
            if (alloc_fire) begin
                entries[tail_idx] <= '{valid: 1'b1, done: 1'b0, dest: alloc_dest, value: '0};
            end
            if (wb_hit) begin
                entries[wb_tag].done  <= 1'b1;
                entries[wb_tag].value <= wb_value;
            end
            if (commit_fire) begin
                entries[head_idx].valid <= 1'b0;
            end
        end
    end

    // Operand lookup ports, identical logic replicated per port
    logic [TAG_W-1:0]  rd_tag_arr   [2];
    logic              rd_ready_arr [2];
    logic [DATA_W-1:0] rd_value_arr [2];

    assign rd_tag_arr[0] = rd_tag0;
    assign rd_tag_arr[1] = rd_tag1;
    assign rd_ready0     = rd_ready_arr[0];
    assign rd_ready1     = rd_ready_arr[1];
    assign rd_value0     = rd_value_arr[0];
    assign rd_value1     = rd_value_arr[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lookup
            entry_t rd_entry;
            logic   rd_byp;

            assign rd_entry = entries[rd_tag_arr[gi]];
`ifdef ROB_WB_BYPASS_EN
            assign rd_byp = wb_hit && (wb_tag == rd_tag_arr[gi]);
`else
            assign rd_byp = 1'b0;
`endif

            // Ready when in flight and done (or being written back right now)
            always_comb begin
                rd_ready_arr[gi] = rd_entry.valid && (rd_entry.done || rd_byp);
                rd_value_arr[gi] = '0;
                if (rd_ready_arr[gi]) begin
                    rd_value_arr[gi] = rd_byp ? wb_value : rd_entry.value;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer (default 64 rows, 6-bit dest, 32-bit data).
module tb_reorder_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        alloc_valid;
    logic [5:0]  alloc_dest;
    logic        alloc_ready;
    logic [5:0]  alloc_tag;
    logic        wb_valid;
    logic [5:0]  wb_tag;
    logic [31:0] wb_value;
    logic [5:0]  rd_tag0, rd_tag1;
    logic        rd_ready0, rd_ready1;
    logic [31:0] rd_value0, rd_value1;
    logic        commit_valid;
    logic [5:0]  commit_dest;
    logic [31:0] commit_value;
    logic        commit_ready;
    logic        flush;
    logic [6:0]  count;
    logic        empty, full;

    int total = 0;
    int bad   = 0;

    reorder_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .alloc_valid  (alloc_valid),
        .alloc_dest   (alloc_dest),
        .alloc_ready  (alloc_ready),
        .alloc_tag    (alloc_tag),
        .wb_valid     (wb_valid),
        .wb_tag       (wb_tag),
        .wb_value     (wb_value),
        .rd_tag0      (rd_tag0),
        .rd_tag1      (rd_tag1),
        .rd_ready0    (rd_ready0),
        .rd_ready1    (rd_ready1),
        .rd_value0    (rd_value0),
        .rd_value1    (rd_value1),
        .commit_valid (commit_valid),
        .commit_dest  (commit_dest),
        .commit_value (commit_value),
        .commit_ready (commit_ready),
        .flush        (flush),
        .count        (count),
        .empty        (empty),
        .full         (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic quiet();
        alloc_valid  = 1'b0;
        alloc_dest   = '0;
        wb_valid     = 1'b0;
        wb_tag       = '0;
        wb_value     = '0;
        commit_ready = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic do_reset();
        quiet();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        settle();
    endtask

    initial begin
        rd_tag0 = '0;
        rd_tag1 = '0;
        do_reset();

        // Reset state
        chk("rst_empty", empty, 1);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_alloc_tag", alloc_tag, 0);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_full", full, 0);
        chk("rst_commit_dest", commit_dest, 0);
        chk("rst_commit_value", commit_value, 0);
        chk("rst_rd_ready0", rd_ready0, 0);
        chk("rst_rd_value0", rd_value0, 0);

        // Allocate dest 5,6,7 as tags 0,1,2
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1'b1;
            alloc_dest  = 6'(5 + i);
            settle();
            chk($sformatf("alloc_tag_%0d", i), alloc_tag, i);
            tick();
        end
        quiet();
        settle();
        chk("count3", count, 3);
        rd_tag1 = 6'd1;
        settle();
        chk("rd1_not_done", rd_ready1, 0);

        // Writeback tag1 then tag0 with retirement held off
        wb_valid = 1'b1; wb_tag = 6'd1; wb_value = 32'hAA;
        tick();
        quiet();
        settle();
        chk("rd1_ready", rd_ready1, 1);
        chk("rd1_value", rd_value1, 32'hAA);
        chk("head_not_done", commit_valid, 0);
        wb_valid = 1'b1; wb_tag = 6'd0; wb_value = 32'h11;
        tick();
        quiet();
        settle();
        chk("c0_valid", commit_valid, 1);
        chk("c0_dest", commit_dest, 5);
        chk("c0_value", commit_value, 32'h11);
        tick();
        chk("stall_valid", commit_valid, 1);
        chk("stall_dest", commit_dest, 5);
        chk("stall_count", count, 3);

        commit_ready = 1'b1;
        tick();
        chk("c1_valid", commit_valid, 1);
        chk("c1_dest", commit_dest, 6);
        chk("c1_value", commit_value, 32'hAA);
        tick();
        chk("tag2_blocks", commit_valid, 0);
        chk("count1", count, 1);
        tick();
        chk("tag2_still_blocks", count, 1);
        wb_valid = 1'b1; wb_tag = 6'd2; wb_value = 32'h22;
        tick();
        wb_valid = 1'b0;
        tick();
        tick();
        commit_ready = 1'b0;
        settle();
        chk("drained", count, 0);
        chk("drained_empty", empty, 1);

        // Fill all 64 rows starting at tag 3
        for (int i = 0; i < 64; i++) begin
            alloc_valid = 1'b1;
            alloc_dest  = 6'(i);
            tick();
        end
        quiet();
        settle();
        chk("full", full, 1);
        chk("full_alloc_ready", alloc_ready, 0);
        chk("full_count", count, 64);
        chk("full_alloc_tag", alloc_tag, 3);
        wb_valid = 1'b1; wb_tag = 6'd3; wb_value = 32'h33;
        tick();
        quiet();
        settle();
        chk("full_head_valid", commit_valid, 1);
        chk("full_head_value", commit_value, 32'h33);
        alloc_valid = 1'b1; alloc_dest = 6'd9; commit_ready = 1'b1;
        tick();
        quiet();
        settle();
        chk("full_commit_count", count, 63);
        chk("full_no_alloc_tag", alloc_tag, 3);
        chk("full_cleared", full, 0);

        // Wrap: 64 alloc / writeback / retire rounds from a clean state
        do_reset();
        commit_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            alloc_valid = 1'b1; alloc_dest = 6'(i);
            tick();
            alloc_valid = 1'b0;
            wb_valid = 1'b1; wb_tag = 6'(i); wb_value = 32'(i);
            tick();
            wb_valid = 1'b0;
            tick();
        end
        quiet();
        settle();
        chk("wrap_count0", count, 0);
        chk("wrap_tag", alloc_tag, 0);
        alloc_valid = 1'b1; alloc_dest = 6'd1;
        tick();
        quiet();
        settle();
        chk("wrap_count1", count, 1);

        // Tags 1..3 allocated, then writeback tag 3 with lookup on it
        for (int i = 1; i < 4; i++) begin
            alloc_valid = 1'b1; alloc_dest = 6'(20 + i);
            tick();
        end
        quiet();
        rd_tag0 = 6'd3; rd_tag1 = 6'd2;
        wb_valid = 1'b1; wb_tag = 6'd3; wb_value = 32'hDEAD;
        settle();
`ifdef ROB_WB_BYPASS_EN
        chk("wb_same_ready", rd_ready0, 1);
        chk("wb_same_value", rd_value0, 32'hDEAD);
`else
        chk("wb_same_ready", rd_ready0, 0);
        chk("wb_same_value", rd_value0, 0);
`endif
        tick();
        quiet();
        settle();
        chk("wb_next_ready", rd_ready0, 1);
        chk("wb_next_value", rd_value0, 32'hDEAD);
        chk("other_not_ready", rd_ready1, 0);
        chk("other_value0", rd_value1, 0);
        chk("head0_not_done", commit_valid, 0);

        // Grow to 10 live entries, then flush with competing alloc/wb/commit
        for (int i = 0; i < 6; i++) begin
            alloc_valid = 1'b1; alloc_dest = 6'(30 + i);
            tick();
        end
        quiet();
        settle();
        chk("live10", count, 10);
        flush = 1'b1; alloc_valid = 1'b1; alloc_dest = 6'd7;
        wb_valid = 1'b1; wb_tag = 6'd0; wb_value = 32'h55; commit_ready = 1'b1;
        tick();
        quiet();
        settle();
        chk("flush_empty", empty, 1);
        chk("flush_count", count, 0);
        chk("flush_tag", alloc_tag, 0);
        chk("flush_rd_old", rd_ready0, 0);
        wb_valid = 1'b1; wb_tag = 6'd0; wb_value = 32'h77;
        tick();
        quiet();
        settle();
        chk("old_wb_commit", commit_valid, 0);
        chk("old_wb_count", count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end
endmodule
